prog_loader: RTL and testbench
==============================

# prog_loader

Program-memory loader: the write-side counterpart of the datapath's instruction-fetch port. It accepts a byte stream over a valid/ready handshake, packs each group of three bytes into one 17-bit instruction word, and writes consecutive words into program memory starting at address 0. While a load is in progress it holds the datapath in reset, and it releases the datapath only after a successful load.

## Interface
- `ADDR_W`, default 8: program-memory address width.
- `INSTR_W`, default 17: instruction word width. Fixed by the ISA; other values are unsupported.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `start` input 1: one-cycle load request. Ignored unless the FSM is in IDLE or DONE.
- `num_words` input ADDR_W+1: number of words to load. Sampled on an accepted `start`. Valid range is 0..2^ADDR_W.
- `byte_valid` input 1: source has a byte on `byte_data`.
- `byte_data` input 8: stream byte.
- `byte_ready` output 1: loader can accept a byte.
- `pm_we` output 1: program-memory write strobe.
- `pm_addr` output ADDR_W: write address.
- `pm_wdata` output INSTR_W: write data.
- `cpu_rst_n` output 1: active-low reset to the datapath.
- `busy` output 1: a load is in progress.
- `done` output 1: the last load completed.
- `err` output 1: the last load failed its checksum. Tied to 0 when `PROG_LOADER_CHECKSUM_EN` is not defined.

## Operation
- FSM states: IDLE, B0, B1, B2, WRITE, CKSUM (only with `PROG_LOADER_CHECKSUM_EN`), DONE.
- IDLE or DONE, on `start`:
  - `num_words` = 0: go to DONE with `done`=1. In the checksum build, go to CKSUM instead.
  - Otherwise: latch the count, clear the address, drive `cpu_rst_n`=0 and `done`=0, go to B0.
- B0, B1 and B2 hold `byte_ready`=1. A byte is accepted when `byte_valid` and `byte_ready` are both high.
  - B0 byte goes to `word[7:0]`.
  - B1 byte goes to `word[15:8]`.
  - B2 byte bit 0 goes to `word[16]`. Bits 7:1 are ignored but are still included in the checksum.
- After the B2 byte is accepted, go to WRITE.
- WRITE (one cycle): `pm_we`=1, `pm_addr`=current address, `pm_wdata`=assembled word. Then increment the address.
  - If more words remain, go to B0.
  - Otherwise go to DONE, or to CKSUM in the checksum build.
- DONE: `done`=1, `busy`=0, `cpu_rst_n`=1 unless `err`=1.
- `busy`=1 in every state except IDLE and DONE.
- `byte_ready`=0 in IDLE, WRITE and DONE. A byte offered in those states is not consumed.
- Address arithmetic is ADDR_W bits. With `num_words`=2^ADDR_W the last write goes to 2^ADDR_W−1 and the address wraps to 0 unused.
- `start` while busy is ignored. No abort exists; only `rst` stops a load.
- Reset asserted mid-load: the FSM goes to IDLE immediately and the partial word is discarded. Memory already written is left as is.

## Timing
- Reset values: `byte_ready`=0, `pm_we`=0, `pm_addr`=0, `pm_wdata`=0, `cpu_rst_n`=0, `busy`=0, `done`=0, `err`=0.
- All outputs are registered or decoded from state only. There is no combinational path from `byte_valid` to `byte_ready`.
- `pm_we` pulses exactly one cycle, in the cycle after the third byte of a word is accepted.
- With a source that holds `byte_valid`=1 continuously, one word costs 4 cycles (3 byte cycles + WRITE).
- The `cpu_rst_n` rise coincides with the first DONE cycle. The datapath sees its reset release on the next edge.
- `pm_addr` and `pm_wdata` hold their last values outside WRITE.

## Configuration
- `PROG_LOADER_CHECKSUM_EN` defined:
  - After the last word, CKSUM accepts one extra byte, with `byte_ready`=1.
  - The expected value is the XOR of all payload bytes, seeded with 8'h00.
  - Match: `err`=0. Mismatch: `err`=1 and `cpu_rst_n` stays 0 in DONE.
  - `err` clears on the next accepted `start`.
- Not defined: no CKSUM state and no accumulator. `err` is constant 0.

## Structure
- `prog_loader_pkg` holds:
  - the state enum;
  - `INSTR_W`=17 and `BYTES_PER_WORD`=3;
  - `CKSUM_SEED`=8'h00.
- Sub-module `prog_loader_cksum`: the XOR accumulator with clear/enable and compare output. It is instantiated only under `PROG_LOADER_CHECKSUM_EN`.

## Test plan
- Reset, then `start` with `num_words`=2 and bytes 34,12,01,CD,AB,00, `byte_valid` held high:
  - writes at 0 with 17'h11234 and at 1 with 17'h0ABCD, 4 cycles apart;
  - `done`=1 and `cpu_rst_n`=1 after the 8th cycle.
- Same load with `byte_valid` toggling every other cycle:
  - identical writes;
  - each `pm_we` falls exactly one cycle after a B2 accept;
  - no byte is lost or duplicated.
- `num_words`=0: DONE in the next cycle, no `pm_we`, `cpu_rst_n`=1. In the checksum build, a trailing byte 00 is required first.
- `rst` pulsed after B1 of word 1: all outputs return to their reset values. A new load of 1 word then writes address 0 correctly.
- `start` re-pulsed while busy: ignored and the load completes unchanged. `num_words`=256: the last write is at address FF.
- Checksum build, 1 word 01,02,00 then checksum 03: `err`=0 and `cpu_rst_n`=1. With checksum 04 instead: `err`=1 and `cpu_rst_n`=0.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program-memory loader.
// The checksum state exists only when PROG_LOADER_CHECKSUM_EN is defined.
package prog_loader_pkg;

    localparam int         INSTR_W        = 17;
    localparam int         BYTES_PER_WORD = 3;
    localparam logic [7:0] CKSUM_SEED     = 8'h00;

    typedef enum logic [2:0] {
        S_IDLE,
        S_B0,
        S_B1,
        S_B2,
        S_WRITE,
`ifdef PROG_LOADER_CHECKSUM_EN
        S_CKSUM,
`endif
        S_DONE
    } state_e;

endpackage

// File: rtl/prog_loader_cksum.sv
// Running XOR over the payload bytes.
// match compares the accumulated value against the byte currently on din.
module prog_loader_cksum
    import prog_loader_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] din,
    output logic       match
);

    logic [7:0] acc_q;
    logic [7:0] acc_d;

    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = CKSUM_SEED;
        end else if (en) begin
            acc_d = acc_q ^ din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= CKSUM_SEED;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign match = (acc_q == din);

endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader: packs 3 bytes per 17-bit word and writes program memory,
// holding the datapath in reset until a good load. Optional checksum: PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = prog_loader_pkg::INSTR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [ADDR_W:0]    num_words,
    input  logic               byte_valid,
    input  logic [7:0]         byte_data,
    output logic               byte_ready,
    output logic               pm_we,
    output logic [ADDR_W-1:0]  pm_addr,
    output logic [INSTR_W-1:0] pm_wdata,
    output logic               cpu_rst_n,
    output logic               busy,
    output logic               done,
    output logic               err
);

    import prog_loader_pkg::*;

    // The low bytes of a word are staged; the final byte's bit 0 goes straight into pm_wdata.
    localparam int LOW_W = (BYTES_PER_WORD - 1) * 8;

    state_e              state_q, state_d;
    logic [ADDR_W:0]     words_left_q, words_left_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LOW_W-1:0]    word_q, word_d;
    logic [ADDR_W-1:0]   pm_addr_q, pm_addr_d;
    logic [INSTR_W-1:0]  pm_wdata_q, pm_wdata_d;
    logic                byte_acc;

`ifdef PROG_LOADER_CHECKSUM_EN
    logic err_q, err_d;
    logic cks_clr, cks_en, cks_match;

    prog_loader_cksum u_cksum (
        .clk   (clk),
        .rst   (rst),
        .clr   (cks_clr),
        .en    (cks_en),
        .din   (byte_data),
        .match (cks_match)
    );
`endif

    assign byte_acc = byte_valid && byte_ready;

    always_comb begin
        state_d      = state_q;
        words_left_d = words_left_q;
        addr_d       = addr_q;
        word_d       = word_q;
        pm_addr_d    = pm_addr_q;
        pm_wdata_d   = pm_wdata_q;
`ifdef PROG_LOADER_CHECKSUM_EN
        err_d        = err_q;
        cks_clr      = 1'b0;
        cks_en       = 1'b0;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                    err_d   = 1'b0;
                    cks_clr = 1'b1;
`endif
                    if (num_words == '0) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                        state_d = S_CKSUM;
`else
                        state_d = S_DONE;
`endif
                    end else begin
                        words_left_d = num_words;
                        addr_d       = '0;
                        state_d      = S_B0;
                    end
                end
            end
            S_B0: begin
                if (byte_acc) begin
                    word_d[7:0] = byte_data;
                    state_d     = S_B1;
                end
            end
            S_B1: begin
                if (byte_acc) begin
                    word_d[15:8] = byte_data;
                    state_d      = S_B2;
                end
            end
            S_B2: begin
                if (byte_acc) begin
                    pm_addr_d  = addr_q;
                    pm_wdata_d = {byte_data[0], word_q};
                    state_d    = S_WRITE;
                end
            end
            S_WRITE: begin
                addr_d       = addr_q + ADDR_W'(1);
                words_left_d = words_left_q - (ADDR_W + 1)'(1);
                if (words_left_q == (ADDR_W + 1)'(1)) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                    state_d = S_CKSUM;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    state_d = S_B0;
                end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            S_CKSUM: begin
                if (byte_acc) begin
                    err_d   = !cks_match;
                    state_d = S_DONE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
`ifdef PROG_LOADER_CHECKSUM_EN
        // Every payload byte, including the ignored high bits of the third, feeds the checksum.
        cks_en = byte_acc && (state_q == S_B0 || state_q == S_B1 || state_q == S_B2);
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            words_left_q <= '0;
            addr_q       <= '0;
            word_q       <= '0;
            pm_addr_q    <= '0;
            pm_wdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            words_left_q <= words_left_d;
            addr_q       <= addr_d;
            word_q       <= word_d;
            pm_addr_q    <= pm_addr_d;
            pm_wdata_q   <= pm_wdata_d;
        end
    end

`ifdef PROG_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
    assign err = err_q;
    assign byte_ready = (state_q == S_B0) || (state_q == S_B1) || (state_q == S_B2) ||
                        (state_q == S_CKSUM);
`else
    assign err = 1'b0;
    assign byte_ready = (state_q == S_B0) || (state_q == S_B1) || (state_q == S_B2);
`endif

    assign pm_we     = (state_q == S_WRITE);
    assign pm_addr   = pm_addr_q;
    assign pm_wdata  = pm_wdata_q;
    assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done      = (state_q == S_DONE);
    assign cpu_rst_n = (state_q == S_DONE) && !err;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: word packing, handshake, reset, zero/full counts, checksum.
module tb_prog_loader;

    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 17;
`ifdef PROG_LOADER_CHECKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               start = 1'b0;
    logic [ADDR_W:0]    num_words = '0;
    logic               byte_valid = 1'b0;
    logic [7:0]         byte_data = 8'h00;
    logic               byte_ready;
    logic               pm_we;
    logic [ADDR_W-1:0]  pm_addr;
    logic [INSTR_W-1:0] pm_wdata;
    logic               cpu_rst_n;
    logic               busy;
    logic               done;
    logic               err;

    logic [7:0] stream [0:1023];
    int errors = 0;
    int checks = 0;
    int cyc, first_we, last_we;

    always #5 clk = ~clk;

    prog_loader #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .num_words  (num_words),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .pm_we      (pm_we),
        .pm_addr    (pm_addr),
        .pm_wdata   (pm_wdata),
        .cpu_rst_n  (cpu_rst_n),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " byte_ready"}, byte_ready, 0);
        check({tag, " pm_we"}, pm_we, 0);
        check({tag, " pm_addr"}, pm_addr, 0);
        check({tag, " pm_wdata"}, pm_wdata, 0);
        check({tag, " cpu_rst_n"}, cpu_rst_n, 0);
        check({tag, " busy"}, busy, 0);
        check({tag, " done"}, done, 0);
        check({tag, " err"}, err, 0);
    endtask

    function automatic logic [7:0] xsum(input int n);
        logic [7:0] x = 8'h00;
        for (int i = 0; i < 3 * n; i++) x = x ^ stream[i];
        return x;
    endfunction

    // Runs one complete load; every cycle checks pm_we against the bench's own
    // record of whether the third byte of a word was accepted on the previous edge.
    task automatic run_load(input string tag, input int n, input bit toggle, input bit repulse,
                            input logic [7:0] cks, input bit exp_err,
                            output int cycles, output int fw, output int lw);
        int total;
        int bi;
        int wi;
        int c;
        bit acc;
        bit third;
        logic [16:0] exp_word;
        total = 3 * n + CK;
        bi = 0;
        wi = 0;
        c = 0;
        fw = -1;
        lw = -1;
        stream[3 * n] = cks;
        num_words = n[ADDR_W:0];
        start = 1'b1;
        tick;
        start = 1'b0;
        check({tag, " err_after_start"}, err, 0);
        check({tag, " busy_after_start"}, busy, (n == 0 && CK == 0) ? 0 : 1);
        while (!done && c < 4000) begin
            byte_valid = (bi < total) && (!toggle || c[0]);
            byte_data  = (bi < total) ? stream[bi] : 8'hEE;
            if (repulse && c == 2) begin
                start = 1'b1;
                num_words = 5;
            end
            acc   = byte_valid && byte_ready;
            third = acc && (bi < 3 * n) && (bi % 3 == 2);
            tick;
            start = 1'b0;
            c++;
            check({tag, " pm_we"}, pm_we, third);
            if (pm_we) begin
                exp_word = {stream[3 * wi + 2][0], stream[3 * wi + 1], stream[3 * wi]};
                check({tag, " pm_addr"}, pm_addr, wi % (1 << ADDR_W));
                check({tag, " pm_wdata"}, pm_wdata, exp_word);
                if (fw < 0) fw = c;
                lw = c;
                wi++;
            end
            if (acc) bi++;
        end
        byte_valid = 1'b0;
        check({tag, " done"}, done, 1);
        check({tag, " bytes_taken"}, bi, total);
        check({tag, " words_written"}, wi, n);
        check({tag, " busy_end"}, busy, 0);
        check({tag, " err_end"}, err, exp_err);
        check({tag, " cpu_rst_n_end"}, cpu_rst_n, !exp_err);
        cycles = c;
    endtask

    initial begin
        rst = 1'b0;
        repeat (2) tick;
        check_reset_values("reset");
        rst = 1'b1;
        tick;

        // Zero-word load straight from IDLE
        run_load("zero", 0, 1'b0, 1'b0, 8'h00, 1'b0, cyc, first_we, last_we);
        check("zero cycles", cyc, CK);

        stream[0] = 8'h34; stream[1] = 8'h12; stream[2] = 8'h01;
        stream[3] = 8'hCD; stream[4] = 8'hAB; stream[5] = 8'h00;
        run_load("basic", 2, 1'b0, 1'b0, xsum(2), 1'b0, cyc, first_we, last_we);
        check("basic cycles", cyc, 8 + CK);
        check("basic first_we", first_we, 3);
        check("basic we_spacing", last_we - first_we, 4);
        check("basic held_addr", pm_addr, 8'h01);
        check("basic held_data", pm_wdata, 17'h0ABCD);

        run_load("toggle", 2, 1'b1, 1'b0, xsum(2), 1'b0, cyc, first_we, last_we);
        check("toggle held_addr", pm_addr, 8'h01);
        check("toggle held_data", pm_wdata, 17'h0ABCD);

        // Reset during B2 of the second word (B0 and B1 already taken)
        num_words = 2;
        start = 1'b1;
        tick;
        start = 1'b0;
        byte_valid = 1'b1;
        byte_data = stream[0]; tick;
        byte_data = stream[1]; tick;
        byte_data = stream[2]; tick;
        byte_data = stream[3]; tick;
        tick;
        byte_data = stream[4]; tick;
        byte_valid = 1'b0;
        check("midload busy", busy, 1);
        check("midload byte_ready", byte_ready, 1);
        check("midload pm_addr", pm_addr, 8'h00);
        #2 rst = 1'b0;
        #1 check_reset_values("midload_rst");
        tick;
        rst = 1'b1;
        tick;
        stream[0] = 8'h55; stream[1] = 8'h66; stream[2] = 8'h01;
        run_load("after_rst", 1, 1'b0, 1'b0, xsum(1), 1'b0, cyc, first_we, last_we);
        check("after_rst addr", pm_addr, 8'h00);
        check("after_rst data", pm_wdata, 17'h16655);

        // Full address space with a start re-pulse mid-load
        for (int i = 0; i < 768; i++) stream[i] = 8'((i * 37 + 11) & 255);
        run_load("full", 256, 1'b0, 1'b1, xsum(256), 1'b0, cyc, first_we, last_we);
        check("full last_addr", pm_addr, 8'hFF);
        check("full cycles", cyc, 1024 + CK);

`ifdef PROG_LOADER_CHECKSUM_EN
        stream[0] = 8'h01; stream[1] = 8'h02; stream[2] = 8'h00;
        run_load("ck_ok", 1, 1'b0, 1'b0, 8'h03, 1'b0, cyc, first_we, last_we);
        check("ck_ok data", pm_wdata, 17'h00201);
        run_load("ck_bad", 1, 1'b0, 1'b0, 8'h04, 1'b1, cyc, first_we, last_we);
        run_load("ck_clear", 1, 1'b0, 1'b0, 8'h03, 1'b0, cyc, first_we, last_we);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
